// File: rtl/param_sync_ram_clr_if.sv
// Request/response bundle for the param_sync_ram_clr word store.
// The master drives requests; the slave (the RAM) returns registered read data and status.
interface param_sync_ram_clr_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 12
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              busy;
  logic              parity_err;

  modport master (
    output wr_en, rd_en, addr, din,
    input  dout, dout_valid, busy, parity_err
  );

  modport slave (
    input  wr_en, rd_en, addr, din,
    output dout, dout_valid, busy, parity_err
  );
endinterface

// File: rtl/param_sync_ram_clr.sv
// Single-port synchronous RAM with registered reads and a post-reset clear engine.
// Optional per-word even parity is enabled by defining RAM_PARITY_EN.
module param_sync_ram_clr #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic                clk,
  input  logic                RE,
  param_sync_ram_clr_if.slave bus
);

`ifdef RAM_PARITY_EN
  localparam int unsigned WORD_W = DATA_W + 1;
`else
  localparam int unsigned WORD_W = DATA_W;
`endif
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [ADDR_W-1:0] clr_ptr_d;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [WORD_W-1:0] mem_wdata_c;
  logic              rd_fire_c;
  logic              in_range_c;
  logic [WORD_W-1:0] rd_word_c;
  logic              rd_perr_c;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              busy_q;
  logic              parity_err_q;

  assign in_range_c = {1'b0, bus.addr} < DEPTH_L;

  // State register; reset restarts the clear sweep from word 0
  always_ff @(posedge clk) begin
    if (RE) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Next state and memory write port selection
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = bus.addr;
`ifdef RAM_PARITY_EN
    mem_wdata_c = {^bus.din, bus.din};
`else
    mem_wdata_c = bus.din;
`endif
    rd_fire_c   = 1'b0;
    case (state_q)
      CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = clr_ptr_q;
        mem_wdata_c = '0;
        clr_ptr_d   = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == LAST_PTR) begin
          state_d   = IDLE;
          clr_ptr_d = '0;
        end
      end
      IDLE: begin
        mem_we_c  = bus.wr_en && in_range_c;
        rd_fire_c = bus.rd_en;
      end
      default: state_d = CLEAR;
    endcase
    if (RE) begin
      mem_we_c  = 1'b0;
      rd_fire_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Out-of-range reads return an all-zero word, which also carries clean parity
  always_comb begin
    rd_word_c = '0;
    if (in_range_c) begin
      rd_word_c = mem[bus.addr];
    end
`ifdef RAM_PARITY_EN
    rd_perr_c = (^rd_word_c[DATA_W-1:0]) != rd_word_c[WORD_W-1];
`else
    rd_perr_c = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (RE) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b1;
      parity_err_q <= 1'b0;
    end else begin
      busy_q       <= (state_d == CLEAR);
      dout_valid_q <= rd_fire_c;
      parity_err_q <= rd_fire_c && rd_perr_c;
      if (rd_fire_c) begin
        dout_q <= rd_word_c[DATA_W-1:0];
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
`ifdef RAM_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_ram_clr.sv
// Directed self-checking bench for param_sync_ram_clr (4096-word and 3000-word instances).
module tb_param_sync_ram_clr;
  logic clk;
  logic RE;
  logic re_s;
  int   errors;
  int   checks;

  param_sync_ram_clr_if #(.DATA_W(24), .ADDR_W(12)) bus ();
  param_sync_ram_clr_if #(.DATA_W(24), .ADDR_W(12)) bus_s ();

  param_sync_ram_clr #(.DATA_W(24), .ADDR_W(12), .DEPTH(4096)) dut (
    .clk (clk),
    .RE  (RE),
    .bus (bus.slave)
  );

  param_sync_ram_clr #(.DATA_W(24), .ADDR_W(12), .DEPTH(3000)) u_small (
    .clk (clk),
    .RE  (re_s),
    .bus (bus_s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [23:0] d);
    bus.addr  = a;
    bus.din   = d;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [23:0] d, output logic v,
                         output logic p);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    d = bus.dout;
    v = bus.dout_valid;
    p = bus.parity_err;
  endtask

  task automatic pulse_reset();
    RE = 1'b1;
    tick();
    RE = 1'b0;
  endtask

  task automatic measure_busy(output int cnt);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 10000) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    logic [23:0] d;
    logic v, p;
    logic [11:0] addrs [3];
    addrs[0] = 12'h000;
    addrs[1] = 12'h7FF;
    addrs[2] = 12'hFFF;
    RE = 1'b1;
    re_s = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.dout !== 24'h0 || bus.dout_valid !== 1'b0 ||
        bus.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b dout=%h valid=%b perr=%b want 1 000000 0 0",
               bus.busy, bus.dout, bus.dout_valid, bus.parity_err);
    end
    RE = 1'b0;
    re_s = 1'b0;
    measure_busy(cnt);
    checks++;
    if (cnt !== 4096) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles want 4096", cnt);
    end
    checks++;
    if (bus_s.busy !== 1'b0) begin
      errors++;
      $display("FAIL small_busy_done: got %b want 0", bus_s.busy);
    end
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], d, v, p);
      checks++;
      if (d !== 24'h0 || v !== 1'b1) begin
        errors++;
        $display("FAIL cleared_read @%h: dout=%h valid=%b want 000000 1", addrs[i], d, v);
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    logic [23:0] d;
    logic v, p;
    do_write(12'h123, 24'hA5A5A5);
    do_read(12'h123, d, v, p);
    checks++;
    if (d !== 24'hA5A5A5 || v !== 1'b1 || p !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd: dout=%h valid=%b perr=%b want a5a5a5 1 0", d, v, p);
    end
    tick();
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.dout !== 24'hA5A5A5) begin
      errors++;
      $display("FAIL valid_strobe_hold: valid=%b dout=%h want 0 a5a5a5",
               bus.dout_valid, bus.dout);
    end
  endtask

  task automatic test_read_first();
    logic [23:0] d;
    logic v, p;
    do_write(12'h010, 24'h111111);
    bus.addr  = 12'h010;
    bus.din   = 24'h222222;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bus.dout !== 24'h111111 || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_first_old: dout=%h valid=%b want 111111 1",
               bus.dout, bus.dout_valid);
    end
    do_read(12'h010, d, v, p);
    checks++;
    if (d !== 24'h222222 || v !== 1'b1) begin
      errors++;
      $display("FAIL read_first_new: dout=%h valid=%b want 222222 1", d, v);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp [3];
    exp[0] = 24'h000ABC;
    exp[1] = 24'h123456;
    exp[2] = 24'hFEDCBA;
    for (int i = 0; i < 3; i++) do_write(12'h200 + 12'(i), exp[i]);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.addr = 12'h200 + 12'(i);
      tick();
      checks++;
      if (bus.dout !== exp[i] || bus.dout_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read[%0d]: dout=%h valid=%b want %h 1",
                 i, bus.dout, bus.dout_valid, exp[i]);
      end
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_busy_ignore();
    int cnt;
    int bad_valid;
    logic [23:0] d;
    logic v, p;
    pulse_reset();
    bus.addr  = 12'h005;
    bus.din   = 24'hFFFFFF;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bad_valid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.dout_valid !== 1'b0) bad_valid++;
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    checks++;
    if (bad_valid !== 0) begin
      errors++;
      $display("FAIL busy_no_valid: got %0d valid cycles want 0", bad_valid);
    end
    measure_busy(cnt);
    checks++;
    if (cnt !== 4096 - 8) begin
      errors++;
      $display("FAIL busy_len2: got %0d remaining want %0d", cnt, 4096 - 8);
    end
    do_read(12'h005, d, v, p);
    checks++;
    if (d !== 24'h0 || v !== 1'b1) begin
      errors++;
      $display("FAIL busy_write_dropped: dout=%h valid=%b want 000000 1", d, v);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    logic [23:0] d;
    logic v, p;
    do_write(12'h300, 24'hABCDEF);
    do_write(12'hFFF, 24'h5A5A5A);
    pulse_reset();
    repeat (100) tick();
    pulse_reset();
    measure_busy(cnt);
    checks++;
    if (cnt !== 4096) begin
      errors++;
      $display("FAIL mid_clear_busy: got %0d cycles want 4096", cnt);
    end
    do_read(12'h300, d, v, p);
    checks++;
    if (d !== 24'h0 || v !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_300: dout=%h valid=%b want 000000 1", d, v);
    end
    do_read(12'hFFF, d, v, p);
    checks++;
    if (d !== 24'h0 || v !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear_fff: dout=%h valid=%b want 000000 1", d, v);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    bus_s.addr  = 12'hBB7;
    bus_s.din   = 24'h0C0FFE;
    bus_s.wr_en = 1'b1;
    tick();
    bus_s.addr  = 12'hC00;
    bus_s.din   = 24'h777777;
    tick();
    bus_s.wr_en = 1'b0;
    bus_s.rd_en = 1'b1;
    tick();
    checks++;
    if (bus_s.dout !== 24'h0 || bus_s.dout_valid !== 1'b1 || bus_s.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_read: dout=%h valid=%b perr=%b want 000000 1 0",
               bus_s.dout, bus_s.dout_valid, bus_s.parity_err);
    end
    bus_s.addr = 12'hBB7;
    tick();
    bus_s.rd_en = 1'b0;
    checks++;
    if (bus_s.dout !== 24'h0C0FFE || bus_s.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL last_word_read: dout=%h valid=%b want 0c0ffe 1",
               bus_s.dout, bus_s.dout_valid);
    end
    tick();
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity();
    logic [23:0] d;
    logic v, p;
    do_write(12'h020, 24'h000001);
    dut.mem[12'h020] = dut.mem[12'h020] ^ 25'h0000001;
    do_read(12'h020, d, v, p);
    checks++;
    if (p !== 1'b1 || v !== 1'b1 || d !== 24'h000000) begin
      errors++;
      $display("FAIL parity_flip: perr=%b valid=%b dout=%h want 1 1 000000", p, v, d);
    end
    tick();
    checks++;
    if (bus.parity_err !== 1'b0) begin
      errors++;
      $display("FAIL parity_idle: perr=%b want 0", bus.parity_err);
    end
  endtask
`endif

  initial begin
    errors       = 0;
    checks       = 0;
    RE           = 1'b1;
    re_s         = 1'b1;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.addr     = '0;
    bus.din      = '0;
    bus_s.wr_en  = 1'b0;
    bus_s.rd_en  = 1'b0;
    bus_s.addr   = '0;
    bus_s.din    = '0;
    test_reset();
    test_write_read();
    test_read_first();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_clear();
    test_out_of_range();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
